// File: rtl/tpu_pkg.sv
// Shared types and sizing constants for the systolic matrix-multiply slice.
package tpu_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_ELEM = 4;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/mmu_loader.sv
// Byte-serial operand loader for the 2x2 systolic multiplier. Assembles A/B,
// pulses mmu_start, holds operands stable, and waits for a fresh done edge.
// Supports weight reuse: an A-only reload keeps the previously stored B.
module mmu_loader #(
  parameter int unsigned ELEM_W  = tpu_pkg::ELEM_W,
  parameter int unsigned N_ELEM  = tpu_pkg::N_ELEM,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ELEM_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       load_a_only,
  output logic [N_ELEM*ELEM_W-1:0]   A_flat,
  output logic [N_ELEM*ELEM_W-1:0]   B_flat,
  output logic                       mmu_start,
  input  logic                       mmu_done,
  output logic                       busy,
  output logic                       run_done,
  output logic                       timeout_err
);

  import tpu_pkg::*;

  localparam int unsigned IdxW  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned TcntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FlatW = N_ELEM * ELEM_W;

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_ELEM - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);

  loader_state_t    state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [FlatW-1:0] a_q, a_d;
  logic [FlatW-1:0] b_q, b_d;
  logic             b_loaded_q, b_loaded_d;
  logic             a_only_q, a_only_d;
  logic             done_q, done_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             terr_q, terr_d;
  logic             a_only_eff;
  logic             done_edge;

  assign A_flat      = a_q;
  assign B_flat      = b_q;
  assign timeout_err = terr_q;

  // Reuse decision is taken on the first A byte; later bytes use the latched value.
  assign a_only_eff = (idx_q == '0) ? (load_a_only & b_loaded_q) : a_only_q;
  // The multiplier's done is not reset, so only a rising edge counts as completion.
  assign done_edge  = mmu_done & ~done_q;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    b_loaded_d = b_loaded_q;
    a_only_d   = a_only_q;
    // Sampled every cycle so a done left high from an earlier run never looks like an edge.
    done_d     = mmu_done;
    tcnt_d     = tcnt_q;
    terr_d     = terr_q;
    in_ready   = 1'b0;
    mmu_start  = 1'b0;
    run_done   = 1'b0;
    busy       = (state_q != LOAD_A) | (idx_q != '0);

    unique case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d[int'(idx_q)*ELEM_W +: ELEM_W] = in_data;
          if (idx_q == '0) a_only_d = load_a_only & b_loaded_q;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = a_only_eff ? START : LOAD_B;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d[int'(idx_q)*ELEM_W +: ELEM_W] = in_data;
          if (idx_q == IdxLast) begin
            idx_d      = '0;
            b_loaded_d = 1'b1;
            state_d    = START;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      START: begin
        mmu_start = 1'b1;
        terr_d    = 1'b0;
        tcnt_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          run_done = 1'b1;
          state_d  = LOAD_A;
        end else if (tcnt_q == TcntLast) begin
          terr_d  = 1'b1;
          state_d = LOAD_A;
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // State registers with synchronous active-high reset; reset also drops the stored B.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_A;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      b_loaded_q <= 1'b0;
      a_only_q   <= 1'b0;
      done_q     <= 1'b0;
      tcnt_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      b_loaded_q <= b_loaded_d;
      a_only_q   <= a_only_d;
      done_q     <= done_d;
      tcnt_q     <= tcnt_d;
      terr_q     <= terr_d;
    end
  end

endmodule

// File: tb/tb_mmu_loader.sv
// Directed self-checking bench for mmu_loader with a behavioural multiplier done model.
module tb_mmu_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_a_only;
  logic [31:0] A_flat;
  logic [31:0] B_flat;
  logic        mmu_start;
  logic        mmu_done = 1'b0;
  logic        busy;
  logic        run_done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  // 0: behavioural multiplier, 1: done tied low, 2: done tied high
  int mode = 0;
  int mcnt = 3;

  int   n;
  logic flag;

  mmu_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .load_a_only (load_a_only),
    .A_flat      (A_flat),
    .B_flat      (B_flat),
    .mmu_start   (mmu_start),
    .mmu_done    (mmu_done),
    .busy        (busy),
    .run_done    (run_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: start clears done, done rises on the 3rd edge after start drops.
  always @(posedge clk) begin
    if (mode == 1) begin
      mmu_done <= 1'b0;
    end else if (mode == 2) begin
      mmu_done <= 1'b1;
    end else if (mmu_start) begin
      mcnt     <= 0;
      mmu_done <= 1'b0;
    end else if (mcnt < 3) begin
      mcnt <= mcnt + 1;
      if (mcnt == 2) mmu_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic lao);
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    load_a_only = lao;
  endtask

  // Ends on the negedge following the last send, i.e. the cycle after its transfer.
  task automatic idle;
    @(negedge clk);
    in_valid    = 1'b0;
    load_a_only = 1'b0;
    in_data     = 8'hEE;
  endtask

  // From a START-cycle negedge, count negedges until run_done; note any early in_ready.
  task automatic wait_run(output int cnt, output logic saw_ready);
    cnt = 0;
    saw_ready = 1'b0;
    while (run_done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (run_done !== 1'b1 && in_ready === 1'b1) saw_ready = 1'b1;
    end
  endtask

  // Count negedges until timeout_err rises; note any run_done seen meanwhile.
  task automatic wait_timeout(output int cnt, output logic saw_done);
    cnt = 0;
    saw_done = 1'b0;
    while (timeout_err !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (run_done === 1'b1) saw_done = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; load_a_only = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", A_flat, 32'h0);
    check("rst_b", B_flat, 32'h0);
    check("rst_start", {31'b0, mmu_start}, 32'h0);
    check("rst_run_done", {31'b0, run_done}, 32'h0);
    check("rst_terr", {31'b0, timeout_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b0;

    // Full load, valid held high
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("full_no_start_early", {31'b0, mmu_start}, 32'h0);
    check("full_ready_b3", {31'b0, in_ready}, 32'h1);
    in_data = 8'h08;
    idle;
    check("full_start", {31'b0, mmu_start}, 32'h1);
    check("full_a", A_flat, 32'h04030201);
    check("full_b", B_flat, 32'h08070605);
    check("full_ready_start", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    check("full_start_one_cycle", {31'b0, mmu_start}, 32'h0);
    wait_run(n, flag);
    check("full_run_latency", 32'(n), 32'd3);
    check("full_ready_low_in_run", {31'b0, flag}, 32'h0);
    @(negedge clk);
    check("full_run_done_pulse", {31'b0, run_done}, 32'h0);
    check("full_ready_after", {31'b0, in_ready}, 32'h1);
    check("full_busy_after", {31'b0, busy}, 32'h0);
    check("full_terr", {31'b0, timeout_err}, 32'h0);

    // Weight reuse: A only, B kept
    send(8'h11, 1'b1); send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);
    idle;
    check("reuse_start", {31'b0, mmu_start}, 32'h1);
    check("reuse_a", A_flat, 32'h14131211);
    check("reuse_b", B_flat, 32'h08070605);
    wait_run(n, flag);
    check("reuse_run_latency", 32'(n), 32'd4);
    check("reuse_b_after", B_flat, 32'h08070605);

    // Reuse request ignored after reset: full 8 bytes required
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_b", B_flat, 32'h0);
    send(8'h21, 1'b1); send(8'h22, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b0);
    idle;
    check("noreuse_no_start", {31'b0, mmu_start}, 32'h0);
    check("noreuse_ready", {31'b0, in_ready}, 32'h1);
    check("noreuse_busy", {31'b0, busy}, 32'h1);
    check("noreuse_a", A_flat, 32'h24232221);
    send(8'h25, 1'b0); send(8'h26, 1'b0); send(8'h27, 1'b0); send(8'h28, 1'b0);
    idle;
    check("noreuse_start", {31'b0, mmu_start}, 32'h1);
    check("noreuse_b", B_flat, 32'h28272625);
    wait_run(n, flag);
    check("noreuse_run_latency", 32'(n), 32'd4);

    // Timeout with done tied low
    mode = 1;
    send(8'h31, 1'b1); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
    idle;
    check("to_start", {31'b0, mmu_start}, 32'h1);
    wait_timeout(n, flag);
    check("to_latency", 32'(n), 32'd9);
    check("to_no_run_done", {31'b0, flag}, 32'h0);
    check("to_ready", {31'b0, in_ready}, 32'h1);
    check("to_a", A_flat, 32'h34333231);

    // Stale done held high: no edge, so no completion; timeout_err cleared at START
    mode = 2;
    send(8'h41, 1'b1); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
    idle;
    check("stale_start", {31'b0, mmu_start}, 32'h1);
    check("stale_terr_held", {31'b0, timeout_err}, 32'h1);
    @(negedge clk);
    check("stale_terr_cleared", {31'b0, timeout_err}, 32'h0);
    wait_timeout(n, flag);
    check("stale_latency", 32'(n), 32'd8);
    check("stale_no_run_done", {31'b0, flag}, 32'h0);
    check("stale_b", B_flat, 32'h28272625);

    // Backpressure: valid every other cycle, junk data in the gaps, then reset mid-stream
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h51 + 8'(i), 1'b0);
      idle;
    end
    check("bp_a", A_flat, 32'h54535251);
    check("bp_b", B_flat, 32'h28272655);
    check("bp_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_a", A_flat, 32'h0);
    check("midrst_b", B_flat, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    send(8'h61, 1'b1); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b0);
    idle;
    check("restart_a", A_flat, 32'h64636261);
    check("restart_no_start", {31'b0, mmu_start}, 32'h0);
    check("restart_ready", {31'b0, in_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
